bcd_share_scheduler: RTL
========================

BCD_SHARE_SCHEDULER -- requirements
Module: bcd_share_scheduler

Interface
REQ-001 Parameter NUM_CH, default 3: number of requesters sharing one binary-to-BCD converter.
REQ-002 Parameter INPUT_WIDTH, default 6: binary width per channel and to the converter.
REQ-003 Parameter DECIMAL_DIGITS, default 2: BCD digits per result.
REQ-004 Parameter TIMEOUT, default 255: maximum WAIT cycles before the scheduler aborts a conversion.
REQ-005 i_Clock  in  1  sole clock; all logic SHALL be rising-edge.
REQ-006 i_Reset  in  1  asynchronous, active-high reset.
REQ-007 i_Req  in  NUM_CH  per-channel one-cycle conversion request.
REQ-008 i_Binary  in  NUM_CH*INPUT_WIDTH  per-channel value; channel k occupies bits [k*INPUT_WIDTH +: INPUT_WIDTH].
REQ-009 o_Conv_Binary  out  INPUT_WIDTH  value presented to the converter.
REQ-010 o_Conv_Start  out  1  converter start strobe.
REQ-011 i_Conv_BCD  in  DECIMAL_DIGITS*4  converter result, valid only in the cycle i_Conv_DV=1.
REQ-012 i_Conv_DV  in  1  converter done strobe.
REQ-013 o_BCD  out  NUM_CH*DECIMAL_DIGITS*4  per-channel held results; channel k occupies bits [k*DECIMAL_DIGITS*4 +: DECIMAL_DIGITS*4].
REQ-014 o_Valid  out  NUM_CH  channel k holds at least one completed result.
REQ-015 o_Done  out  NUM_CH  one-cycle pulse when channel k's result updates.
REQ-016 o_Err  out  NUM_CH  sticky timeout flag per channel.
REQ-017 o_Busy  out  1  high whenever the state is not IDLE.

Function
REQ-018 When i_Req[k]=1, the block SHALL set pending[k] and capture channel k's i_Binary into val[k] on the same edge; a repeated request SHALL overwrite val[k] (latest wins).
REQ-019 The FSM states SHALL be IDLE, START, WAIT and STORE.
REQ-020 IDLE: if any pending bit is set, the block SHALL grant the first pending channel searching round-robin from last_grant+1, clear that pending bit, load o_Conv_Binary from its val, record the grant, and go to START.
REQ-021 START: o_Conv_Start SHALL be 1 for exactly this one cycle, and the FSM SHALL go to WAIT with the timeout counter cleared.
REQ-022 WAIT: on i_Conv_DV=1 the block SHALL capture i_Conv_BCD into the granted channel's o_BCD slice and set its o_Valid bit, then go to STORE; otherwise it SHALL increment the counter.
REQ-023 WAIT: when the counter reaches TIMEOUT without i_Conv_DV, the block SHALL set o_Err[grant], leave o_BCD unchanged, and go to IDLE.
REQ-024 STORE: o_Done[grant] SHALL pulse for one cycle and the FSM SHALL go to IDLE.
REQ-025 o_Conv_Binary SHALL hold stable from START until the FSM leaves WAIT.
REQ-026 Any i_Conv_DV outside WAIT SHALL be ignored.
REQ-027 If i_Req[k] coincides with the IDLE grant clearing pending[k], pending[k] SHALL stay set and val[k] SHALL take the new value; the granted conversion SHALL use the old val.
REQ-028 A request on the channel currently in service SHALL re-arm pending and be served on a later grant.
REQ-029 The round-robin pointer SHALL wrap from NUM_CH-1 to 0.
REQ-030 Latency: with the block idle, a request at edge N SHALL give o_Conv_Start=1 in cycle N+2 and o_Done one cycle after the i_Conv_DV capture edge.
REQ-031 o_Err bits SHALL clear only on reset.

Reset
REQ-032 While i_Reset=1, asynchronously: state SHALL be IDLE; pending, val, o_BCD, o_Valid, o_Done, o_Err, o_Conv_Start, o_Conv_Binary and o_Busy SHALL be 0; last_grant SHALL be NUM_CH-1, so channel 0 wins first.
REQ-033 Reset asserted mid-conversion SHALL abort it with no o_Done pulse and no o_BCD update.

Verification
REQ-034 Single request: ch1 requests value 42, converter model answers 8'h42 after 20 cycles -> o_Conv_Start at N+2, o_BCD[15:8]=8'h42, o_Valid=3'b010, o_Done[1] single pulse.
REQ-035 Simultaneous requests: all three channels request 5, 17, 63 on one edge -> service order ch0, ch1, ch2; results 05, 17, 63; exactly three start strobes.
REQ-036 Fairness: ch0 re-requests continuously while ch2 requests once -> ch2 is granted before ch0's second grant.
REQ-037 Timeout: converter never asserts DV -> after TIMEOUT WAIT cycles o_Err[grant]=1, o_BCD unchanged, o_Busy drops, the next pending channel is served.
REQ-038 Collision: ch0 requests 9 in the grant cycle of its earlier request of 3 -> conversions of 3 then 9; final o_BCD[7:0]=8'h09.
REQ-039 Reset in WAIT: all outputs 0 and state IDLE immediately; a late i_Conv_DV is ignored.

Source files
------------

// File: rtl/bcd_share_scheduler_if.sv
// bcd_share_scheduler_if: request, converter and result signals of the shared BCD scheduler
interface bcd_share_scheduler_if #(
  parameter int NUM_CH = 3,
  parameter int INPUT_WIDTH = 6,
  parameter int DECIMAL_DIGITS = 2
);
  logic [NUM_CH-1:0] i_Req;
  logic [NUM_CH*INPUT_WIDTH-1:0] i_Binary;
  logic [INPUT_WIDTH-1:0] o_Conv_Binary;
  logic o_Conv_Start;
  logic [DECIMAL_DIGITS*4-1:0] i_Conv_BCD;
  logic i_Conv_DV;
  logic [NUM_CH*DECIMAL_DIGITS*4-1:0] o_BCD;
  logic [NUM_CH-1:0] o_Valid;
  logic [NUM_CH-1:0] o_Done;
  logic [NUM_CH-1:0] o_Err;
  logic o_Busy;
  modport master (
    output i_Req, i_Binary, i_Conv_BCD, i_Conv_DV,
    input  o_Conv_Binary, o_Conv_Start, o_BCD, o_Valid, o_Done, o_Err, o_Busy
  );
  modport slave (
    input  i_Req, i_Binary, i_Conv_BCD, i_Conv_DV,
    output o_Conv_Binary, o_Conv_Start, o_BCD, o_Valid, o_Done, o_Err, o_Busy
  );
endinterface

// File: rtl/bcd_share_scheduler.sv
// bcd_share_scheduler: round-robin sharing of one binary-to-BCD converter among NUM_CH requesters
module bcd_share_scheduler #(
  parameter int NUM_CH = 3,
  parameter int INPUT_WIDTH = 6,
  parameter int DECIMAL_DIGITS = 2,
  parameter int TIMEOUT = 255
) (
  input logic i_Clock,
  input logic i_Reset,
  bcd_share_scheduler_if.slave bus
);
  localparam int BW = DECIMAL_DIGITS * 4;
  localparam int GW = NUM_CH > 1 ? $clog2(NUM_CH) : 1;
  localparam int CW = TIMEOUT > 0 ? $clog2(TIMEOUT + 1) : 1;
  typedef enum logic [1:0] {IDLE, START, WAIT, STORE} state_t;
  state_t state, state_nxt;
  logic [NUM_CH-1:0] pending;
  logic [INPUT_WIDTH-1:0] val [NUM_CH];
  logic [GW-1:0] last_grant, sel;
  logic [CW-1:0] cnt;
  logic [INPUT_WIDTH-1:0] conv_binary;
  logic [NUM_CH*BW-1:0] bcd;
  logic [NUM_CH-1:0] valid, err;
  logic take, dv_take, tmo;
  function automatic logic [GW-1:0] rr(input logic [GW-1:0] lg, input int i);
    int j;
    j = int'(lg) + i;
    j = j >= NUM_CH ? j - NUM_CH : j;
    return GW'(j);
  endfunction
  assign take = state == IDLE && |pending;
  assign dv_take = state == WAIT && bus.i_Conv_DV;
  assign tmo = state == WAIT && !bus.i_Conv_DV && cnt == CW'(TIMEOUT);
  // first pending channel after the last grant; scanning backwards lets the nearest one win
  always_comb begin
    sel = '0;
    for (int i = NUM_CH; i >= 1; i--) if (pending[rr(last_grant, i)]) sel = rr(last_grant, i);
  end
  // next state: grant, one start cycle, wait for done or timeout, one store cycle
  always_comb begin
    state_nxt = state;
    state_nxt = state == IDLE  ? (take ? START : IDLE) :
                state == START ? WAIT :
                state == WAIT  ? (dv_take ? STORE : (tmo ? IDLE : WAIT)) : IDLE;
  end
  // state register
  always_ff @(posedge i_Clock or posedge i_Reset)
    if (i_Reset) state <= IDLE;
    else state <= state_nxt;
  // request capture, grant bookkeeping, timeout counter and per-channel results
  always_ff @(posedge i_Clock or posedge i_Reset)
    if (i_Reset) begin
      pending <= '0;
      val <= '{default: '0};
      last_grant <= GW'(NUM_CH - 1);
      cnt <= '0;
      conv_binary <= '0;
      bcd <= '0;
      valid <= '0;
      err <= '0;
    end else begin
      pending <= (pending & ~(take ? NUM_CH'(1) << sel : '0)) | bus.i_Req;
      for (int k = 0; k < NUM_CH; k++) if (bus.i_Req[k]) val[k] <= bus.i_Binary[k*INPUT_WIDTH +: INPUT_WIDTH];
      if (take) begin
        last_grant <= sel;
        conv_binary <= val[sel];
      end
      cnt <= state == WAIT ? cnt + 1'b1 : '0;
      if (dv_take) begin
        bcd[last_grant*BW +: BW] <= bus.i_Conv_BCD;
        valid[last_grant] <= 1'b1;
      end
      if (tmo) err[last_grant] <= 1'b1;
    end
  assign bus.o_Conv_Binary = conv_binary;
  assign bus.o_Conv_Start = state == START;
  assign bus.o_BCD = bcd;
  assign bus.o_Valid = valid;
  assign bus.o_Done = state == STORE ? NUM_CH'(1) << last_grant : '0;
  assign bus.o_Err = err;
  assign bus.o_Busy = state != IDLE;
endmodule
